// File: rtl/pipe_ctrl_pkg.sv
// Shared core package for the pipeline controller: state encoding and stall masks.
// Stall masks freeze a prefix of the pipeline registers, starting at postif_id.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } pipe_state_e;

    localparam logic [3:0] STALL_NONE = 4'b0000;
    localparam logic [3:0] STALL_IF   = 4'b0001;
    localparam logic [3:0] STALL_ID   = 4'b0011;
    localparam logic [3:0] STALL_EX   = 4'b0111;
    localparam logic [3:0] STALL_ALL  = 4'b1111;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: per-stage stall priority, exception drain and redirect.
// Optional stalled-cycle counter stall_cnt_o is built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        if_busy_i,
    input  logic        load_use_i,
    input  logic        div_busy_i,
    input  logic        mem_busy_i,
    input  logic        bus_idle_i,
    input  logic        exception_i,
    input  logic [31:0] exc_target_i,
    output logic [3:0]  stall_o,
    output logic        flush_o,
    output logic        new_pc_valid_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    pipe_state_e state_q, state_d;
    logic [31:0] target_q, target_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Only IDLE accepts an exception, so the first target sticks until the flush.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            IDLE: begin
                if (exception_i) begin
                    target_d = exc_target_i;
                    state_d  = bus_idle_i ? FLUSH : DRAIN;
                end
            end
            DRAIN: begin
                if (bus_idle_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o        = STALL_NONE;
        flush_o        = 1'b0;
        new_pc_valid_o = 1'b0;
        new_pc_o       = target_q;
        busy_o         = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (exception_i || mem_busy_i) begin
                    stall_o = STALL_ALL;
                end else if (div_busy_i) begin
                    stall_o = STALL_EX;
                end else if (load_use_i) begin
                    stall_o = STALL_ID;
                end else if (if_busy_i) begin
                    stall_o = STALL_IF;
                end
            end
            DRAIN: stall_o = STALL_ALL;
            FLUSH: begin
                flush_o        = 1'b1;
                new_pc_valid_o = 1'b1;
            end
            default: stall_o = STALL_NONE;
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush_o) begin
            stall_cnt_d = '0;
        end else if (stall_o != STALL_NONE) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle model comparison plus directed literal checks.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_busy, load_use, div_busy, mem_busy, bus_idle, exc;
    logic [31:0] exc_target;
    logic [3:0]  stall;
    logic        flush, npv, busy;
    logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_ctrl dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .if_busy_i     (if_busy),
        .load_use_i    (load_use),
        .div_busy_i    (div_busy),
        .mem_busy_i    (mem_busy),
        .bus_idle_i    (bus_idle),
        .exception_i   (exc),
        .exc_target_i  (exc_target),
        .stall_o       (stall),
        .flush_o       (flush),
        .new_pc_valid_o(npv),
        .new_pc_o      (new_pc),
        .busy_o        (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted exception is either waiting for the bus or flushing this cycle.
    bit          m_waiting;
    bit          m_flushing;
    logic [31:0] m_target;
    logic [31:0] m_cnt;

    function automatic logic [3:0] m_stall();
        if (m_flushing) return 4'd0;
        if (m_waiting || exc || mem_busy) return 4'd15;
        if (div_busy) return 4'd7;
        if (load_use) return 4'd3;
        if (if_busy) return 4'd1;
        return 4'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_waiting  = 1'b0;
            m_flushing = 1'b0;
            m_target   = 32'd0;
            m_cnt      = 32'd0;
        end else begin
            m_cnt = m_flushing ? 32'd0 : m_cnt + ((m_stall() != 4'd0) ? 32'd1 : 32'd0);
            if (m_flushing) begin
                m_flushing = 1'b0;
            end else if (m_waiting) begin
                if (bus_idle) begin
                    m_waiting  = 1'b0;
                    m_flushing = 1'b1;
                end
            end else if (exc) begin
                m_target   = exc_target;
                m_flushing = bus_idle;
                m_waiting  = !bus_idle;
            end
        end
    end

    bit run_cmp = 1'b0;
    always @(negedge clk) begin
        if (run_cmp) begin
            check32("model_stall", {28'd0, stall}, {28'd0, m_stall()});
            check32("model_flush", {31'd0, flush}, {31'd0, m_flushing});
            check32("model_npv",   {31'd0, npv},   {31'd0, m_flushing});
            check32("model_new_pc", new_pc, m_target);
            check32("model_busy",  {31'd0, busy},  {31'd0, m_waiting | m_flushing});
`ifdef PIPE_CTRL_PERF_EN
            check32("model_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v);
        {mem_busy, div_busy, load_use, if_busy} = v;
    endtask

    logic [3:0] vec_in  [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b1000, 4'b1111};
    logic [3:0] vec_exp [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};

    initial begin
        int f_cycles;
        int flush_seen;
        rst = 1'b1;
        set_req(4'b0000);
        bus_idle = 1'b1;
        exc = 1'b0;
        exc_target = 32'd0;
        run_cmp = 1'b1;
        @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_flush", {31'd0, flush}, 32'd0);
        check32("reset_new_pc", new_pc, 32'd0);
        step();
        rst = 1'b0;

        // Stall priority in IDLE
        for (int unsigned i = 0; i < 8; i++) begin
            set_req(vec_in[i]);
            @(negedge clk);
            check32("prio_stall", {28'd0, stall}, {28'd0, vec_exp[i]});
            step();
        end
        set_req(4'b0000);

        // Exception with bus idle: flush next cycle, one cycle wide
        exc = 1'b1;
        exc_target = 32'hBFC00380;
        @(negedge clk);
        check32("exc_stall", {28'd0, stall}, 32'hF);
        check32("exc_no_flush_yet", {31'd0, flush}, 32'd0);
        step();
        exc = 1'b0;
        mem_busy = 1'b1;
        @(negedge clk);
        check32("flush_hi", {31'd0, flush}, 32'd1);
        check32("flush_npv", {31'd0, npv}, 32'd1);
        check32("flush_pc", new_pc, 32'hBFC00380);
        check32("flush_stall_none", {28'd0, stall}, 32'd0);
        step();
        mem_busy = 1'b0;
        @(negedge clk);
        check32("flush_one_wide", {31'd0, flush}, 32'd0);
        check32("flush_idle", {31'd0, busy}, 32'd0);
        check32("pc_hold", new_pc, 32'hBFC00380);
        step();

        // Exception with bus busy 5 cycles; second exception in DRAIN ignored
        f_cycles = 0;
        flush_seen = 0;
        for (int i = 0; i < 6; i++) begin
            bus_idle = (i == 5);
            exc = (i == 0) || (i == 2);
            exc_target = (i == 0) ? 32'hA0000100 : 32'h80000000;
            load_use = (i == 3);
            @(negedge clk);
            if (stall == 4'hF) f_cycles++;
            if (flush) flush_seen++;
            step();
        end
        exc = 1'b0;
        load_use = 1'b0;
        @(negedge clk);
        check32("drain_stall_cycles", f_cycles, 32'd6);
        check32("drain_early_flush", flush_seen, 32'd0);
        check32("drain_flush", {31'd0, flush}, 32'd1);
        check32("drain_first_target", new_pc, 32'hA0000100);
        step();

`ifdef PIPE_CTRL_PERF_EN
        // Counter: 7 stalled cycles, then cleared by a flush
        step();
        if_busy = 1'b1;
        repeat (7) step();
        if_busy = 1'b0;
        @(negedge clk);
        check32("perf_cnt7", stall_cnt, 32'd7);
        exc = 1'b1;
        exc_target = 32'h00001000;
        step();
        exc = 1'b0;
        step();
        @(negedge clk);
        check32("perf_cleared", stall_cnt, 32'd0);
        step();
`endif

        // Reset mid-DRAIN abandons the redirect
        bus_idle = 1'b0;
        exc = 1'b1;
        exc_target = 32'h9FC00000;
        step();
        exc = 1'b0;
        step();
        @(negedge clk);
        check32("pre_reset_drain", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check32("async_busy", {31'd0, busy}, 32'd0);
        check32("async_flush", {31'd0, flush}, 32'd0);
        check32("async_npv", {31'd0, npv}, 32'd0);
        check32("async_pc", new_pc, 32'd0);
        check32("async_stall", {28'd0, stall}, 32'd0);
        step();
        rst = 1'b0;
        bus_idle = 1'b1;
        flush_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (flush) flush_seen++;
            step();
        end
        check32("no_flush_after_reset", flush_seen, 32'd0);
        check32("idle_after_reset", {31'd0, busy}, 32'd0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1);
    end

endmodule
